// File: rtl/keypad_pkg.sv
// keypad_pkg -- shared types and constants for the 4x4 keypad scanner.
//   ROWS, COLS   : keypad geometry
//   CODE_W       : width of a key code (row*4+col)
//   key_state_t  : debounce FSM states
//   frame_class_t: result of classifying one complete scan frame
//   classify_frame / lowest_key : helpers used on the frame map
package keypad_pkg;

  localparam int ROWS   = 4;
  localparam int COLS   = 4;
  localparam int KEYS   = ROWS * COLS;
  localparam int CODE_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    DEBOUNCE,
    PRESSED,
    RELEASE
  } key_state_t;

  typedef enum logic [1:0] {
    NONE,
    SINGLE,
    MULTI
  } frame_class_t;

  function automatic frame_class_t classify_frame(input logic [KEYS-1:0] map);
    logic [4:0] ones;
    ones = '0;
    for (int i = 0; i < KEYS; i++) begin
      ones = ones + {4'b0000, map[i]};
    end
    if (ones == 5'd0) begin
      return NONE;
    end else if (ones == 5'd1) begin
      return SINGLE;
    end
    return MULTI;
  endfunction

  // Only meaningful when the map holds exactly one key.
  function automatic logic [CODE_W-1:0] lowest_key(input logic [KEYS-1:0] map);
    logic [CODE_W-1:0] code;
    code = '0;
    for (int i = KEYS - 1; i >= 0; i--) begin
      if (map[i]) begin
        code = CODE_W'(i);
      end
    end
    return code;
  endfunction

endpackage

// File: rtl/keypad_debounce.sv
// keypad_debounce -- frame-level debounce FSM for the keypad scanner.
// Evaluated once per scan frame; turns the per-frame classification into
// accepted key events.
// Optional feature: define KEYPAD_SCAN_REPEAT_EN to re-pulse key_valid every
// REPEAT_FRAMES frames while a key stays in PRESSED.
// Ports:
//   clk, rst     : clock, synchronous active-low reset
//   frame_end    : one-cycle strobe on the last cycle of each frame
//   frame_class  : NONE / SINGLE / MULTI for the frame just completed
//   frame_code   : key code of the frame when SINGLE
//   key_code     : last accepted key
//   key_valid    : one-cycle strobe per accepted key (and per repeat)
//   key_held     : high from acceptance until release is debounced
module keypad_debounce
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_FRAMES = 4,
  parameter int REPEAT_FRAMES   = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              frame_end,
  input  frame_class_t      frame_class,
  input  logic [CODE_W-1:0] frame_code,
  output logic [CODE_W-1:0] key_code,
  output logic              key_valid,
  output logic              key_held
);

  localparam logic [3:0] DEB_LAST = 4'(DEBOUNCE_FRAMES);

  key_state_t        state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [CODE_W-1:0] cand_q, cand_d;
  logic [CODE_W-1:0] code_q, code_d;
  logic              valid_q, valid_d;

`ifdef KEYPAD_SCAN_REPEAT_EN
  localparam int REP_W = $clog2(REPEAT_FRAMES + 1);
  localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_FRAMES - 1);
  logic [REP_W-1:0] rep_q, rep_d;
`else
  logic unused_repeat_cfg;
  assign unused_repeat_cfg = (REPEAT_FRAMES > 0);
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      cand_q  <= '0;
      code_q  <= '0;
      valid_q <= 1'b0;
`ifdef KEYPAD_SCAN_REPEAT_EN
      rep_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cand_q  <= cand_d;
      code_q  <= code_d;
      valid_q <= valid_d;
`ifdef KEYPAD_SCAN_REPEAT_EN
      rep_q   <= rep_d;
`endif
    end
  end

  // cnt_q counts matching frames in DEBOUNCE and empty frames in RELEASE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cand_d  = cand_q;
    code_d  = code_q;
    valid_d = 1'b0;
`ifdef KEYPAD_SCAN_REPEAT_EN
    rep_d   = rep_q;
`endif
    if (frame_end) begin
      case (state_q)
        IDLE: begin
          if (frame_class == SINGLE) begin
            state_d = DEBOUNCE;
            cand_d  = frame_code;
            cnt_d   = 4'd1;
          end
        end
        DEBOUNCE: begin
          if (frame_class == SINGLE) begin
            if (frame_code != cand_q) begin
              cand_d = frame_code;
              cnt_d  = 4'd1;
            end else if (cnt_q + 4'd1 == DEB_LAST) begin
              state_d = PRESSED;
              code_d  = cand_q;
              valid_d = 1'b1;
              cnt_d   = '0;
`ifdef KEYPAD_SCAN_REPEAT_EN
              rep_d   = '0;
`endif
            end else begin
              cnt_d = cnt_q + 4'd1;
            end
          end else begin
            state_d = IDLE;
            cnt_d   = '0;
          end
        end
        PRESSED: begin
          // Any non-empty frame keeps the key; a new key needs a full release.
          if (frame_class == NONE) begin
            state_d = RELEASE;
            cnt_d   = 4'd1;
          end else begin
`ifdef KEYPAD_SCAN_REPEAT_EN
            if (rep_q == REP_LAST) begin
              rep_d   = '0;
              valid_d = 1'b1;
            end else begin
              rep_d = rep_q + REP_W'(1);
            end
`endif
          end
        end
        RELEASE: begin
          if (frame_class != NONE) begin
            state_d = PRESSED;
            cnt_d   = '0;
`ifdef KEYPAD_SCAN_REPEAT_EN
            rep_d   = '0;
`endif
          end else if (cnt_q + 4'd1 == DEB_LAST) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_comb begin
    key_code  = code_q;
    key_valid = valid_q;
    key_held  = (state_q == PRESSED) || (state_q == RELEASE);
  end

endmodule

// File: rtl/keypad_scan.sv
// keypad_scan -- 4x4 matrix keypad scanner with debounce.
// Rows are driven one at a time (active-low); columns are synchronized,
// sampled at the end of each row dwell and collected into a per-frame map
// that is classified and handed to keypad_debounce.
// Optional feature: define KEYPAD_SCAN_REPEAT_EN for auto-repeat.
// Ports:
//   clk       : system clock
//   rst       : synchronous active-low reset
//   col_n     : column sense, active-low, asynchronous
//   row_n     : row drive, active-low one-hot
//   key_code  : accepted key, row*4+col
//   key_valid : one-cycle strobe per accepted key event
//   key_held  : high while an accepted key remains pressed
module keypad_scan
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV_W      = 8,
  parameter int DEBOUNCE_FRAMES = 4,
  parameter int REPEAT_FRAMES   = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [COLS-1:0]   col_n,
  output logic [ROWS-1:0]   row_n,
  output logic [CODE_W-1:0] key_code,
  output logic              key_valid,
  output logic              key_held
);

  localparam int DIV_W = SCAN_DIV_W + 2;

  logic [COLS-1:0]   col_meta, col_sync;
  logic [DIV_W-1:0]  div_q;
  logic [1:0]        row_sel;
  logic              dwell_end;
  logic              frame_end;
  logic [KEYS-1:0]   row_hits;
  logic [KEYS-1:0]   frame_q, frame_now;
  frame_class_t      frame_class;
  logic [CODE_W-1:0] frame_code;

  always_ff @(posedge clk) begin
    if (!rst) begin
      col_meta <= '1;
      col_sync <= '1;
      div_q    <= '0;
      frame_q  <= '0;
    end else begin
      col_meta <= col_n;
      col_sync <= col_meta;
      div_q    <= div_q + DIV_W'(1);
      frame_q  <= frame_end ? '0 : frame_now;
    end
  end

  // The row-3 sample lands in the same cycle the frame is classified, so the
  // classifier looks at the map with the current sample already merged in.
  always_comb begin
    row_sel   = div_q[DIV_W-1 -: 2];
    dwell_end = &div_q[SCAN_DIV_W-1:0];
    frame_end = dwell_end && (row_sel == 2'd3);
    row_hits  = {{(KEYS-COLS){1'b0}}, ~col_sync} << {row_sel, 2'b00};
    frame_now = frame_q | (dwell_end ? row_hits : '0);
    row_n     = ~(4'b0001 << row_sel);
  end

  always_comb begin
    frame_class = classify_frame(frame_now);
    frame_code  = lowest_key(frame_now);
  end

  keypad_debounce #(
    .DEBOUNCE_FRAMES(DEBOUNCE_FRAMES),
    .REPEAT_FRAMES  (REPEAT_FRAMES)
  ) u_debounce (
    .clk        (clk),
    .rst        (rst),
    .frame_end  (frame_end),
    .frame_class(frame_class),
    .frame_code (frame_code),
    .key_code   (key_code),
    .key_valid  (key_valid),
    .key_held   (key_held)
  );

endmodule

// File: tb/tb_keypad_scan.sv
// tb_keypad_scan -- self-checking bench for keypad_scan.
// A keypad model turns the set of held keys into col_n from row_n; a
// frame-level reference model predicts row_n, key_valid, key_code and
// key_held every cycle. Directed scenarios pin the model with literal
// expectations, then a randomized phase exercises it further.
module tb_keypad_scan;

  localparam int SCAN_DIV_W = 2;
  localparam int DEB        = 4;
  localparam int REP        = 3;
  localparam int FRAME      = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] col_n;
  logic [3:0] row_n;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;

  logic [15:0] keys = '0;
  logic        rst_q = 1'b0;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int          t = 0;
  logic [15:0] ph [4];
  logic [15:0] fmap = '0;
  int          streak = 0;
  int          cand = 0;
  int          rel = 0;
  int          rep = 0;
  bit          held = 1'b0;
  bit          exp_valid = 1'b0;
  int          exp_code = 0;

  // Observed events
  int valid_count = 0;
  int last_code = -1;
  int last_valid_t = -1;
  int fall_t = -1;
  bit prev_held = 1'b0;
  int stim_t = 0;

  keypad_scan #(
    .SCAN_DIV_W     (SCAN_DIV_W),
    .DEBOUNCE_FRAMES(DEB),
    .REPEAT_FRAMES  (REP)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .col_n    (col_n),
    .row_n    (row_n),
    .key_code (key_code),
    .key_valid(key_valid),
    .key_held (key_held)
  );

  always #5 clk = ~clk;

  always_comb begin
    col_n = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (keys[r*4+c] && !row_n[r]) col_n[c] = 1'b0;
      end
    end
  end

  always @(posedge clk) rst_q <= rst;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, actual, expected, t);
    end
  endtask

  always @(negedge clk) begin : compare
    int n;
    int fc;
    int r;
    if (!rst_q) begin
      checkOutput("reset_row_n", int'(row_n), 14);
      checkOutput("reset_key_code", int'(key_code), 0);
      checkOutput("reset_key_valid", int'(key_valid), 0);
      checkOutput("reset_key_held", int'(key_held), 0);
      t = 1;
      fmap = '0;
      streak = 0;
      cand = 0;
      rel = 0;
      rep = 0;
      held = 1'b0;
      exp_valid = 1'b0;
      exp_code = 0;
      prev_held = 1'b0;
      for (int i = 0; i < 4; i++) ph[i] = '0;
    end else begin
      r = (t / 4) % 4;
      checkOutput("row_n", int'(row_n), 15 ^ (1 << r));
      checkOutput("key_valid", int'(key_valid), int'(exp_valid));
      checkOutput("key_code", int'(key_code), exp_code);
      checkOutput("key_held", int'(key_held), int'(held));
      if (key_valid) begin
        valid_count++;
        last_code = int'(key_code);
        last_valid_t = t;
      end
      if (prev_held && !key_held) fall_t = t;
      prev_held = key_held;

      exp_valid = 1'b0;
      ph[t % 4] = keys;
      if (t % 4 == 3) begin
        fmap = fmap | (ph[(t - 2) % 4] & (16'hF << (4 * r)));
      end
      if (t % FRAME == FRAME - 1) begin
        n = $countones(fmap);
        fc = 0;
        for (int i = 0; i < 16; i++) if (fmap[i]) fc = i;
        fmap = '0;
        if (!held) begin
          if (n == 1) begin
            if (streak > 0 && cand == fc) streak++;
            else begin
              cand = fc;
              streak = 1;
            end
            if (streak == DEB) begin
              held = 1'b1;
              streak = 0;
              rel = 0;
              rep = 0;
              exp_valid = 1'b1;
              exp_code = cand;
            end
          end else begin
            streak = 0;
          end
        end else if (rel == 0) begin
          if (n == 0) rel = 1;
          else begin
`ifdef KEYPAD_SCAN_REPEAT_EN
            rep++;
            if (rep == REP) begin
              rep = 0;
              exp_valid = 1'b1;
            end
`endif
          end
        end else begin
          if (n == 0) begin
            rel++;
            if (rel == DEB) begin
              held = 1'b0;
              rel = 0;
            end
          end else begin
            rel = 0;
            rep = 0;
          end
        end
      end
      t++;
    end
  end

  // Holds a key set from the start of the next frame for the given frames.
  task automatic applyStimulus(input logic [15:0] k, input int frames);
    int guard;
    guard = 0;
    while (t % FRAME != 0 && guard < 40) begin
      @(posedge clk);
      #1;
      guard++;
    end
    if (t % FRAME != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL frame_align: got cycle %0d expected frame start", t);
    end
    keys = k;
    stim_t = t;
    repeat (frames * FRAME) @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
    #2;
  endtask

  task automatic clearEvents();
    valid_count = 0;
    last_code = -1;
    last_valid_t = -1;
    fall_t = -1;
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout expected $finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin : stimulus
    int repeats;
    int sel;
`ifdef KEYPAD_SCAN_REPEAT_EN
    repeats = 3;
`else
    repeats = 0;
`endif
    rst = 1'b0;
    keys = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;

    $display("[TB] idle scan");
    clearEvents();
    applyStimulus(16'h0000, 2);
    settle();
    checkOutput("idle_valid_count", valid_count, 0);

    $display("[TB] key 9 press and release");
    clearEvents();
    applyStimulus(16'h0200, 6);
    settle();
    checkOutput("k9_valid_count", valid_count, 1);
    checkOutput("k9_code", last_code, 9);
    checkOutput("k9_latency", last_valid_t - stim_t, 64);
    checkOutput("k9_held", int'(key_held), 1);
    applyStimulus(16'h0000, 6);
    settle();
    checkOutput("k9_release_latency", fall_t - stim_t, 64);
    checkOutput("k9_released_held", int'(key_held), 0);
    checkOutput("k9_single_event", valid_count, 1);

    $display("[TB] bounce on key 6");
    clearEvents();
    applyStimulus(16'h0040, 2);
    applyStimulus(16'h0000, 1);
    applyStimulus(16'h0040, 3);
    settle();
    checkOutput("bounce_no_event", valid_count, 0);
    applyStimulus(16'h0040, 2);
    settle();
    checkOutput("bounce_valid_count", valid_count, 1);
    checkOutput("bounce_code", last_code, 6);
    applyStimulus(16'h0000, 6);

    $display("[TB] keys 0 and 5 together");
    clearEvents();
    applyStimulus(16'h0021, 5);
    settle();
    checkOutput("multi_no_event", valid_count, 0);
    applyStimulus(16'h0001, 5);
    settle();
    checkOutput("multi_then_k0_count", valid_count, 1);
    checkOutput("multi_then_k0_code", last_code, 0);
    applyStimulus(16'h0000, 6);

    $display("[TB] glitch during release");
    clearEvents();
    applyStimulus(16'h0008, 6);
    applyStimulus(16'h0000, 2);
    applyStimulus(16'h0008, 1);
    settle();
    checkOutput("glitch_held", int'(key_held), 1);
    applyStimulus(16'h0000, 6);
    settle();
    checkOutput("glitch_valid_count", valid_count, 1);
    checkOutput("glitch_released", int'(key_held), 0);

    $display("[TB] key 15 held");
    clearEvents();
    applyStimulus(16'h8000, 14);
    settle();
    checkOutput("k15_valid_count", valid_count, 1 + repeats);
    checkOutput("k15_code", last_code, 15);
    applyStimulus(16'h0000, 6);

    $display("[TB] reset during press");
    clearEvents();
    applyStimulus(16'h0200, 6);
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    clearEvents();
    applyStimulus(16'h0200, 6);
    settle();
    checkOutput("post_reset_count", valid_count, 1);
    checkOutput("post_reset_code", last_code, 9);
    applyStimulus(16'h0000, 6);

    $display("[TB] randomized keys");
    for (int seg = 0; seg < 60; seg++) begin
      sel = $urandom_range(0, 9);
      if (sel < 2) keys = '0;
      else if (sel < 7) keys = 16'(16'h1 << $urandom_range(0, 15));
      else if (sel < 9) keys = 16'((16'h1 << $urandom_range(0, 15)) | (16'h1 << $urandom_range(0, 15)));
      if (seg == 30) begin
        rst = 1'b0;
        repeat ($urandom_range(1, 4)) @(posedge clk);
        #1;
        rst = 1'b1;
      end
      repeat ($urandom_range(1, 100)) @(posedge clk);
      #1;
    end
    keys = '0;
    repeat (6 * FRAME) @(posedge clk);
    settle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/keypad_scan.md
KEYPAD_SCAN -- requirements
Module: keypad_scan

Interface
REQ-001 Parameter SCAN_DIV_W, default 8: row dwell is 2^SCAN_DIV_W clk cycles (256 us at 1 MHz).
REQ-002 Parameter DEBOUNCE_FRAMES, default 4: consecutive identical scan frames needed to accept a press or a release; legal range 2..15.
REQ-003 Parameter REPEAT_FRAMES, default 64: auto-repeat period in frames; used only when the repeat feature is compiled in.
REQ-004 Reset rst, synchronous, active-low; clock clk.
REQ-005 clk  input  1  system clock, 1 MHz nominal.
REQ-006 rst  input  1  synchronous active-low reset.
REQ-007 col_n  input  4  keypad column sense, active-low, externally pulled up, asynchronous.
REQ-008 row_n  output  4  row drive, active-low one-hot; bit r low means row r is driven.
REQ-009 key_code  output  4  accepted key, encoded as row*4+col.
REQ-010 key_valid  output  1  one-cycle strobe for each accepted key event.
REQ-011 key_held  output  1  high while an accepted key remains pressed.

Function
REQ-012 col_n SHALL pass through a 2-flop synchronizer; all logic uses the synchronized value only.
REQ-013 A free-running divider of width SCAN_DIV_W+2 SHALL drive the scan: the top 2 bits select the row (0,1,2,3, then wrap to 0), and row_n = ~(1<<row).
REQ-014 The columns SHALL be sampled in the last cycle of each row dwell; the sample is ORed into a 16-bit frame map at bit row*4+col.
REQ-015 At frame end (last cycle of row 3), the frame SHALL be classified as NONE (0 bits set), SINGLE (exactly 1 bit set, with its code), or MULTI (2 or more bits set). The map is then cleared.
REQ-016 The FSM SHALL have states IDLE, DEBOUNCE, PRESSED, RELEASE and is evaluated only at frame end.
REQ-017 IDLE: SINGLE -> DEBOUNCE, with the candidate code latched and the count set to 1; otherwise stay in IDLE.
REQ-018 DEBOUNCE, SINGLE with the same code: increment the count; when it reaches DEBOUNCE_FRAMES -> PRESSED.
REQ-019 DEBOUNCE, SINGLE with a different code: restart with the new candidate and count 1. NONE or MULTI -> IDLE.
REQ-020 Entering PRESSED SHALL load key_code, pulse key_valid high for exactly the next clk cycle, and set key_held = 1.
REQ-021 PRESSED: NONE -> RELEASE with count 1. SINGLE (any code) or MULTI: stay in PRESSED with no new event; a different key requires a full release first.
REQ-022 RELEASE: NONE increments the count; at DEBOUNCE_FRAMES -> IDLE and key_held = 0. Any SINGLE or MULTI -> PRESSED with no new key_valid.
REQ-023 key_code SHALL hold its last accepted value until the next acceptance.
REQ-024 Worst-case press latency SHALL be (DEBOUNCE_FRAMES+1) frames + 3 clk cycles from the col_n edge.

Reset
REQ-025 While rst = 0 at a clk edge: row_n = 4'b1110, key_code = 0, key_valid = 0, key_held = 0, state IDLE, divider, counters and frame map = 0, synchronizer flops = 4'b1111.
REQ-026 Reset asserted mid-frame or mid-press SHALL discard all partial state; a key still held after release of reset requires a full debounce and produces a fresh key_valid.

Configuration
REQ-027 Macro KEYPAD_SCAN_REPEAT_EN, when defined: in PRESSED, every REPEAT_FRAMES consecutive frames without leaving PRESSED SHALL re-pulse key_valid with the same key_code. The repeat counter is cleared on entry to PRESSED and held in RELEASE.
REQ-028 Without KEYPAD_SCAN_REPEAT_EN: exactly one key_valid per press, and no repeat counter is synthesized.

Structure
REQ-029 Package keypad_pkg SHALL hold the FSM state enum, the ROWS = 4 and COLS = 4 constants, the key-code width, and the NONE/SINGLE/MULTI classification type.
REQ-030 Sub-module keypad_debounce SHALL contain the FSM, the counters and the repeat logic; its inputs are the frame-end strobe, the classification and the code.

Verification (SCAN_DIV_W = 2, frame = 16 cycles, DEBOUNCE_FRAMES = 4, REPEAT_FRAMES = 3)
REQ-031 Reset release, no key -> row_n sequence 1110, 1101, 1011, 0111, with 4 cycles per row; key_valid stays 0.
REQ-032 Key row 2 / col 1 held for 6 frames -> one key_valid pulse with key_code = 9 within 5 frames + 3 cycles; key_held = 1.
REQ-033 Bounce (press for 2 frames, release for 1 frame, press again) -> no key_valid until 4 consecutive matching frames.
REQ-034 Keys 0 and 5 pressed together -> no key_valid; releasing key 5 -> key_valid with key_code = 0 after debounce.
REQ-035 Key released after acceptance -> key_held falls 4 frames after release; a 1-frame glitch inside RELEASE returns to PRESSED with no key_valid.
REQ-036 With KEYPAD_SCAN_REPEAT_EN, key 15 held for 10 frames after acceptance -> 3 repeat key_valid pulses, each with key_code = 15; without the macro -> 0 repeats.
